// File: rtl/decode_pkg.sv
// rtl/decode_pkg.sv - shared widths, field slices, opcodes and FSM states for the decode stage
package decode_pkg;

    localparam int IW = 24;
    localparam int AW = 8;
    localparam int RW = 4;

    localparam int OPC_HI = 23;
    localparam int OPC_LO = 20;
    localparam int RD_HI  = 19;
    localparam int RD_LO  = 16;
    localparam int RA_HI  = 15;
    localparam int RA_LO  = 12;
    localparam int RB_HI  = 11;
    localparam int RB_LO  = 8;
    localparam int IMM_HI = 7;
    localparam int IMM_LO = 0;

    typedef enum logic [3:0] {
        OP_NOP   = 4'h0,
        OP_ALU1  = 4'h1,
        OP_ALU2  = 4'h2,
        OP_ALU3  = 4'h3,
        OP_ALU4  = 4'h4,
        OP_ALU5  = 4'h5,
        OP_ALU6  = 4'h6,
        OP_ALU7  = 4'h7,
        OP_JMP   = 4'h8,
        OP_BZ    = 4'h9,
        OP_BNZ   = 4'hA,
        OP_LDC   = 4'hB,
        OP_DJNZ  = 4'hC,
        OP_ILL_D = 4'hD,
        OP_ILL_E = 4'hE,
        OP_HALT  = 4'hF
    } opcode_e;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_FLUSH = 2'd1,
        ST_HALT  = 2'd2
    } state_e;

    function automatic logic is_alu(input logic [3:0] opc);
        return (opc != 4'h0) && !opc[3];
    endfunction

endpackage

// File: rtl/branch_unit.sv
// rtl/branch_unit.sv - combinational control-flow resolution for one decoded opcode
module branch_unit
    import decode_pkg::*;
(
    input  logic [3:0]    opcode_i,
    input  logic [7:0]    imm_i,
    input  logic          zero_flag_i,
    input  logic [7:0]    loop_cnt_i,
    output logic          taken_o,
    output logic [AW-1:0] target_o,
    output logic          is_halt_o,
    output logic          is_illegal_o
);

    always_comb begin
        taken_o      = 1'b0;
        is_halt_o    = 1'b0;
        is_illegal_o = 1'b0;
        case (opcode_e'(opcode_i))
            OP_JMP:             taken_o      = 1'b1;
            OP_BZ:              taken_o      = zero_flag_i;
            OP_BNZ:             taken_o      = !zero_flag_i;
            // Pre-decrement count: 0 wraps to 255 and still loops.
            OP_DJNZ:            taken_o      = (loop_cnt_i != 8'd1);
            OP_HALT:            is_halt_o    = 1'b1;
            OP_ILL_D, OP_ILL_E: is_illegal_o = 1'b1;
            default:            ;
        endcase
    end

    assign target_o = imm_i;

endmodule

// File: rtl/decode_control.sv
// rtl/decode_control.sv - IF/ID register, decode FSM and branch redirect back to fetch
module decode_control
    import decode_pkg::*;
(
    input  logic          CLK,
    input  logic          reset_n,
    input  logic [IW-1:0] instr,
    input  logic          zero_flag,
    output logic          PCSrc,
    output logic [AW-1:0] immediate,
    output logic          ex_valid,
    output logic [2:0]    alu_op,
    output logic [RW-1:0] rd,
    output logic [RW-1:0] ra,
    output logic [RW-1:0] rb,
    output logic [7:0]    ex_imm,
    output logic [AW-1:0] id_pc,
    output logic          halted,
    output logic          illegal
);

    state_e        state_q;
    logic [IW-1:0] ir_q;
    logic [AW-1:0] fetch_pc_q;
    logic [AW-1:0] id_pc_q;
    logic [7:0]    loop_cnt_q;
    logic          ex_valid_q;
    logic [2:0]    alu_op_q;
    logic [RW-1:0] rd_q;
    logic [RW-1:0] ra_q;
    logic [RW-1:0] rb_q;
    logic [7:0]    ex_imm_q;
    logic          halted_q;
    logic          illegal_q;

    logic [3:0]    opc;
    logic          br_taken;
    logic [AW-1:0] br_target;
    logic          br_halt;
    logic          br_illegal;
    logic          freeze_ir;

    assign opc = ir_q[OPC_HI:OPC_LO];

    branch_unit u_branch (
        .opcode_i     (opc),
        .imm_i        (ir_q[IMM_HI:IMM_LO]),
        .zero_flag_i  (zero_flag),
        .loop_cnt_i   (loop_cnt_q),
        .taken_o      (br_taken),
        .target_o     (br_target),
        .is_halt_o    (br_halt),
        .is_illegal_o (br_illegal)
    );

    always_comb begin
        PCSrc     = 1'b0;
        immediate = '0;
        case (state_q)
            ST_RUN: begin
                if (br_taken) begin
                    PCSrc     = 1'b1;
                    immediate = br_target;
                end else if (br_halt) begin
                    PCSrc     = 1'b1;
                    immediate = id_pc_q;
                end
            end
            ST_HALT: begin
                PCSrc     = 1'b1;
                immediate = id_pc_q;
            end
            default: ;
        endcase
    end

    // IF/ID also freezes on the edge entering HALT so id_pc keeps the HALT address.
    assign freeze_ir = (state_q == ST_HALT) || ((state_q == ST_RUN) && br_halt);

    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_FLUSH;
            ir_q       <= '0;
            fetch_pc_q <= '0;
            id_pc_q    <= '0;
            loop_cnt_q <= '0;
            ex_valid_q <= 1'b0;
            alu_op_q   <= '0;
            rd_q       <= '0;
            ra_q       <= '0;
            rb_q       <= '0;
            ex_imm_q   <= '0;
            halted_q   <= 1'b0;
            illegal_q  <= 1'b0;
        end else begin
            fetch_pc_q <= PCSrc ? immediate : fetch_pc_q + 8'd1;
            if (!freeze_ir) begin
                ir_q    <= instr;
                id_pc_q <= fetch_pc_q;
            end
            ex_valid_q <= 1'b0;
            case (state_q)
                ST_RUN: begin
                    if (is_alu(opc)) begin
                        ex_valid_q <= 1'b1;
                        alu_op_q   <= opc[2:0];
                        rd_q       <= ir_q[RD_HI:RD_LO];
                        ra_q       <= ir_q[RA_HI:RA_LO];
                        rb_q       <= ir_q[RB_HI:RB_LO];
                        ex_imm_q   <= ir_q[IMM_HI:IMM_LO];
                    end
                    if (opc == OP_LDC)  loop_cnt_q <= ir_q[IMM_HI:IMM_LO];
                    if (opc == OP_DJNZ) loop_cnt_q <= loop_cnt_q - 8'd1;
                    if (br_illegal)     illegal_q  <= 1'b1;
                    if (br_taken) begin
                        state_q <= ST_FLUSH;
                    end else if (br_halt) begin
                        state_q  <= ST_HALT;
                        halted_q <= 1'b1;
                    end
                end
                ST_FLUSH: state_q <= ST_RUN;
                default:  state_q <= ST_HALT;
            endcase
        end
    end

    assign ex_valid = ex_valid_q;
    assign alu_op   = alu_op_q;
    assign rd       = rd_q;
    assign ra       = ra_q;
    assign rb       = rb_q;
    assign ex_imm   = ex_imm_q;
    assign id_pc    = id_pc_q;
    assign halted   = halted_q;
    assign illegal  = illegal_q;

endmodule

// File: tb/tb_decode_control.sv
// tb/tb_decode_control.sv - directed and random program runs against an instruction-level reference
module tb_decode_control;
    import decode_pkg::*;

    logic          CLK = 1'b0;
    logic          reset_n = 1'b1;
    logic [IW-1:0] instr;
    logic          zero_flag = 1'b0;
    logic          PCSrc;
    logic [AW-1:0] immediate;
    logic          ex_valid;
    logic [2:0]    alu_op;
    logic [RW-1:0] rd, ra, rb;
    logic [7:0]    ex_imm;
    logic [AW-1:0] id_pc;
    logic          halted;
    logic          illegal;

    always #5 CLK = ~CLK;

    decode_control dut (
        .CLK       (CLK),
        .reset_n   (reset_n),
        .instr     (instr),
        .zero_flag (zero_flag),
        .PCSrc     (PCSrc),
        .immediate (immediate),
        .ex_valid  (ex_valid),
        .alu_op    (alu_op),
        .rd        (rd),
        .ra        (ra),
        .rb        (rb),
        .ex_imm    (ex_imm),
        .id_pc     (id_pc),
        .halted    (halted),
        .illegal   (illegal)
    );

    // Fetch stage environment: PC register plus program ROM.
    logic [23:0] rom [0:255];
    logic [7:0]  fpc;
    always @(posedge CLK or negedge reset_n) begin
        if (!reset_n) fpc <= 8'd0;
        else          fpc <= PCSrc ? immediate : fpc + 8'd1;
    end
    assign instr = rom[fpc];

    // Reference: mode 0 = bubble (m_pc is next address to decode), 1 = decode m_pc, 2 = halted at m_pc.
    int         m_mode;
    logic [7:0] m_pc;
    logic [7:0] m_loop;
    logic       m_exv;
    logic [2:0] m_alu;
    logic [3:0] m_rd, m_ra, m_rb;
    logic [7:0] m_imm;
    logic       m_ill;

    int checks = 0;
    int errors = 0;
    int zf_mode = 2;
    int cyc, first_exv, exv_count, pc_count;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [23:0] gen_alu();
        logic [3:0] op;
        op = 4'($urandom_range(1, 7));
        return {op, 20'($urandom)};
    endfunction

    function automatic logic [23:0] gen_any();
        logic [3:0] op;
        op = 4'($urandom_range(0, 15));
        if (op == 4'hF && $urandom_range(0, 7) != 0) op = 4'h1;
        return {op, 20'($urandom)};
    endfunction

    task automatic fill_alu();
        for (int i = 0; i < 256; i++) rom[i] = gen_alu();
    endtask

    task automatic model_reset();
        m_mode = 0; m_pc = 8'd0; m_loop = 8'd0; m_exv = 1'b0;
        m_alu = '0; m_rd = '0; m_ra = '0; m_rb = '0; m_imm = '0; m_ill = 1'b0;
    endtask

    // Called at posedge+1; asserts reset, checks async clear, releases at next posedge+1.
    task automatic do_reset();
        reset_n = 1'b0;
        #1;
        chk("rst_PCSrc", PCSrc, 0);
        chk("rst_immediate", immediate, 0);
        chk("rst_ex_valid", ex_valid, 0);
        chk("rst_alu_op", alu_op, 0);
        chk("rst_rd", rd, 0);
        chk("rst_ra", ra, 0);
        chk("rst_rb", rb, 0);
        chk("rst_ex_imm", ex_imm, 0);
        chk("rst_id_pc", id_pc, 0);
        chk("rst_halted", halted, 0);
        chk("rst_illegal", illegal, 0);
        model_reset();
        @(posedge CLK);
        #1;
        reset_n = 1'b1;
        cyc = 0; first_exv = 0; exv_count = 0; pc_count = 0;
    endtask

    // One clock cycle: drive zero_flag, check at negedge, advance reference.
    task automatic cycle();
        logic [23:0] w;
        logic [3:0]  op;
        logic        tk;
        if (zf_mode == 2) zero_flag = 1'($urandom_range(0, 1));
        else              zero_flag = (zf_mode == 1);
        #4;
        cyc++;
        if (ex_valid === 1'b1) begin
            exv_count++;
            if (first_exv == 0) first_exv = cyc;
        end
        if (PCSrc === 1'b1) pc_count++;
        chk("ex_valid", ex_valid, m_exv);
        chk("alu_op", alu_op, m_alu);
        chk("rd", rd, m_rd);
        chk("ra", ra, m_ra);
        chk("rb", rb, m_rb);
        chk("ex_imm", ex_imm, m_imm);
        chk("illegal", illegal, m_ill);
        chk("halted", halted, m_mode == 2);
        if (m_mode == 1) begin
            w  = rom[m_pc];
            op = w[23:20];
            tk = (op == 4'h8) || (op == 4'h9 && zero_flag) || (op == 4'hA && !zero_flag) ||
                 (op == 4'hC && m_loop != 8'd1);
            chk("id_pc", id_pc, m_pc);
            chk("PCSrc", PCSrc, tk || op == 4'hF);
            chk("immediate", immediate, tk ? w[7:0] : (op == 4'hF ? m_pc : 8'd0));
            m_exv = (op >= 4'h1 && op <= 4'h7);
            if (m_exv) begin
                m_alu = op[2:0]; m_rd = w[19:16]; m_ra = w[15:12]; m_rb = w[11:8]; m_imm = w[7:0];
            end
            if (op == 4'hB) m_loop = w[7:0];
            if (op == 4'hC) m_loop = m_loop - 8'd1;
            if (op == 4'hD || op == 4'hE) m_ill = 1'b1;
            if (tk) begin
                m_mode = 0; m_pc = w[7:0];
            end else if (op == 4'hF) begin
                m_mode = 2;
            end else begin
                m_pc = m_pc + 8'd1;
            end
        end else if (m_mode == 0) begin
            chk("bubble_PCSrc", PCSrc, 0);
            chk("bubble_immediate", immediate, 0);
            m_exv = 1'b0;
            m_mode = 1;
        end else begin
            chk("halt_id_pc", id_pc, m_pc);
            chk("halt_PCSrc", PCSrc, 1);
            chk("halt_immediate", immediate, m_pc);
            m_exv = 1'b0;
        end
        @(posedge CLK);
        #1;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    initial begin
        fill_alu();
        #2;
        @(posedge CLK);
        #1;

        // Straight-line ALU program
        zf_mode = 2;
        do_reset();
        run(8);
        chk("first_ex_valid_cycle", first_exv, 3);
        chk("straight_pcsrc_cycles", pc_count, 0);

        // JMP 0x20 at address 2
        fill_alu();
        rom[2] = 24'h800020;
        do_reset();
        run(10);
        chk("jmp_pcsrc_cycles", pc_count, 1);

        // BZ 0x10 at address 5, not taken then taken
        fill_alu();
        rom[5] = 24'h900010;
        zf_mode = 0;
        do_reset();
        run(10);
        chk("bz_nt_pcsrc_cycles", pc_count, 0);
        zf_mode = 1;
        do_reset();
        run(10);
        chk("bz_t_pcsrc_cycles", pc_count, 1);
        zf_mode = 2;

        // LDC 3 / ALU / DJNZ loop, then DJNZ with count 0 and count 255
        fill_alu();
        rom[0]    = 24'hB00003;
        rom[2]    = 24'hC00001;
        rom[3]    = 24'hC00030;
        rom[8'h30] = 24'hC00040;
        do_reset();
        run(12);
        chk("loop_body_execs", exv_count, 3);
        run(10);

        // HALT at 7, reset mid-HALT
        fill_alu();
        rom[7] = 24'hF00000;
        do_reset();
        run(22);
        do_reset();
        run(6);

        // Illegal opcode at 3
        fill_alu();
        rom[3] = 24'hD00000;
        do_reset();
        run(12);
        chk("illegal_sticky", illegal, 1);

        // Random programs with random zero flag
        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < 256; i++) rom[i] = gen_any();
            do_reset();
            run(150);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/decode_control.md
Name: decode_control

Overview:
- ID stage directly downstream of the instruction ROM/PC fetch stage.
- Registers the 24-bit fetched instruction into an IF/ID pipeline register and decodes it.
- Resolves control flow (JMP, BZ, BNZ, loop-counter DJNZ, HALT) and drives PCSrc/immediate back to fetch.
- Hands ALU instructions to execute with a valid strobe; one bubble per taken branch.

Parameters:
- IW, 24, instruction width.
- AW, 8, instruction address width (fetch PC and branch target).
- RW, 4, register-specifier width.

Ports:
- CLK  in  1  clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset. Fetch stage is driven with reset = ~reset_n.
- instr  in  IW  fetched instruction for the current fetch PC (combinational from ROM).
- zero_flag  in  1  Z flag from execute, sampled in the decode cycle.
- PCSrc  out  1  1 = fetch loads immediate next edge; 0 = fetch increments.
- immediate  out  AW  branch target to fetch.
- ex_valid  out  1  registered; alu_op/rd/ra/rb/ex_imm valid this cycle.
- alu_op  out  3  registered ALU operation (opcode[2:0]).
- rd, ra, rb  out  RW each  registered register specifiers.
- ex_imm  out  8  registered instruction immediate.
- id_pc  out  AW  address of the instruction held in IF/ID.
- halted  out  1  1 while in HALT.
- illegal  out  1  sticky; set on decode of an undefined opcode.

Behaviour:
- Encoding: [23:20] opcode, [19:16] rd, [15:12] ra, [11:8] rb, [7:0] imm.
- Opcodes:
  - 0x0 NOP.
  - 0x1-0x7 ALU: alu_op = opcode[2:0].
  - 0x8 JMP: always taken.
  - 0x9 BZ: taken if zero_flag = 1.
  - 0xA BNZ: taken if zero_flag = 0.
  - 0xB LDC: loop_cnt <= imm.
  - 0xC DJNZ: loop_cnt <= loop_cnt-1 (8-bit wrap); taken if loop_cnt != 1, so loop_cnt = 0 wraps to 255 and is taken.
  - 0xF HALT.
  - 0xD, 0xE illegal: behave as NOP and set illegal.
- Fetch-PC mirror fetch_pc: every edge <= PCSrc ? immediate : fetch_pc+1, wrapping 255 -> 0.
- IF/ID register: every edge outside HALT, ir <= instr and id_pc <= fetch_pc.
- FSM states, RUN / FLUSH / HALT:
  - RUN: decode ir.
    - Taken branch: PCSrc = 1, immediate = ir[7:0], next state FLUSH.
    - HALT: PCSrc = 1, immediate = id_pc, next state HALT.
    - Otherwise: PCSrc = 0, stay in RUN.
  - FLUSH: ir holds the wrong-path instruction. Treat it as a bubble: no ex_valid, no loop_cnt or illegal update, PCSrc = 0. Next state RUN.
  - HALT: PCSrc = 1 and immediate = id_pc every cycle. ir and id_pc frozen, ex_valid = 0, halted = 1. Exit only via reset.
- Branch latency: branch decoded in cycle n; fetch PC = target after edge n; target instruction decoded in cycle n+2.
- ex_valid <= 1 at the edge ending a RUN-cycle ALU decode. Execute fields are updated only then and otherwise hold their last values.
- PCSrc and immediate are combinational from state, ir, zero_flag and loop_cnt. immediate = 0 when PCSrc = 0.
- Reset (asynchronous, any cycle, including mid-FLUSH or mid-HALT):
  - State FLUSH, so the first post-reset ir is discarded as a bubble.
  - ir = 0 (NOP), fetch_pc = 0, id_pc = 0, loop_cnt = 0.
  - ex_valid = 0, alu_op/rd/ra/rb/ex_imm = 0, halted = 0, illegal = 0.
  - PCSrc = 0, immediate = 0.
- Address 0 is first decoded in the second cycle after reset_n rises.
- Simultaneous events: a branch in FLUSH is ignored. DJNZ updates loop_cnt and evaluates taken from the pre-decrement value in the same cycle. LDC followed immediately by DJNZ sees the new count.

Decomposition:
- Package decode_pkg:
  - opcode_e enum with the opcodes above.
  - state_e {RUN, FLUSH, HALT}.
  - Field-slice localparams (OPC_HI/LO, RD_HI/LO, ...).
  - Width constants IW, AW, RW.
- Sub-module branch_unit, combinational: (opcode, imm, zero_flag, loop_cnt) -> (taken, target, is_halt, is_illegal). FSM and registers stay in decode_control.

Test Plan:
- Reset then straight-line program 0x100000 ... (five ALU ops at addr 0-4):
  - PCSrc stays 0.
  - ex_valid rises in cycle 3 after reset_n rises.
  - id_pc steps 0,1,2,3,4.
- JMP 0x20 at addr 2:
  - PCSrc = 1 with immediate = 0x20 for exactly one cycle.
  - Next decoded cycle is a FLUSH bubble (ex_valid = 0); then id_pc = 0x20.
- BZ 0x10 at addr 5 with zero_flag = 0, then rerun with zero_flag = 1:
  - zero_flag = 0: no redirect, id_pc = 6 follows.
  - zero_flag = 1: redirect to 0x10.
- Loop: addr0 LDC 3, addr1 ALU, addr2 DJNZ 1:
  - Addr 1 executes 3 times; DJNZ taken twice, not taken on the third pass.
  - id_pc then reaches 3; loop_cnt = 0.
  - Also run DJNZ with loop_cnt = 0: taken, loop_cnt = 255.
- HALT at addr 7:
  - halted = 1; PCSrc = 1, immediate = 7 held for 10+ cycles; ex_valid = 0.
  - reset_n pulsed low mid-HALT: all outputs return to reset values asynchronously.
- Opcode 0xD at addr 3:
  - illegal = 1 and stays set; no ex_valid for it.
  - Subsequent instructions execute normally.
